router_merge: RTL

- Reverse path of the 4-way address router: merges four independent input streams into one output stream.
- Tags each output beat with its 2-bit source index, so a downstream router can re-split it.
- Round-robin arbitration, valid/ready handshake on every port, one registered output stage.
- Sits between four producer lanes and a single shared consumer/link.

---
 rtl/router_pkg.sv | 8 +
 rtl/rr_arbiter4.sv | 27 ++
 rtl/router_merge.sv | 118 +++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the 4-way address router and its merge (reverse) path.
package router_pkg;

  localparam int NUM_PORTS = 4;

  typedef logic [1:0] port_idx_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter4
  import router_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            ptr,
  output logic                 grant_valid,
  output port_idx_t            grant_idx
);

  port_idx_t idx;

  // Walk from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr;
    idx         = ptr;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = ptr + port_idx_t'(i);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/router_merge.sv
// Merges four valid/ready streams into one registered, source-tagged stream.
// Optional accepted-beat counter on beat_cnt when ROUTER_MERGE_CNT_EN is defined.
module router_merge
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32
`ifdef ROUTER_MERGE_CNT_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic                  din_en0,
  input  logic                  din_en1,
  input  logic                  din_en2,
  input  logic                  din_en3,
  output logic                  din_rdy0,
  output logic                  din_rdy1,
  output logic                  din_rdy2,
  output logic                  din_rdy3,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            dout_addr,
  output logic                  dout_en,
  input  logic                  dout_ready
`ifdef ROUTER_MERGE_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  beat_cnt
`endif
);

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  port_idx_t             addr_q, addr_d;
  logic                  en_q, en_d;
  port_idx_t             rr_ptr_q, rr_ptr_d;

  logic                  load;
  logic                  grant_valid;
  port_idx_t             grant_idx;
  logic [DATA_WIDTH-1:0] din_sel;

  assign load = !en_q || dout_ready;

  rr_arbiter4 u_arb (
    .req         ({din_en3, din_en2, din_en1, din_en0}),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Handshake is gated by resetn so no producer sees an accept during reset.
  assign din_rdy0 = resetn && load && grant_valid && (grant_idx == 2'd0);
  assign din_rdy1 = resetn && load && grant_valid && (grant_idx == 2'd1);
  assign din_rdy2 = resetn && load && grant_valid && (grant_idx == 2'd2);
  assign din_rdy3 = resetn && load && grant_valid && (grant_idx == 2'd3);

  always_comb begin
    case (grant_idx)
      2'd0:    din_sel = din0;
      2'd1:    din_sel = din1;
      2'd2:    din_sel = din2;
      default: din_sel = din3;
    endcase
  end

  always_comb begin
    dout_d   = dout_q;
    addr_d   = addr_q;
    en_d     = en_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      if (grant_valid) begin
        dout_d   = din_sel;
        addr_d   = grant_idx;
        en_d     = 1'b1;
        rr_ptr_d = grant_idx + 2'd1;
      end else begin
        en_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_q   <= '0;
      addr_q   <= '0;
      en_q     <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      dout_q   <= dout_d;
      addr_q   <= addr_d;
      en_q     <= en_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign dout      = dout_q;
  assign dout_addr = addr_q;
  assign dout_en   = en_q;

`ifdef ROUTER_MERGE_CNT_EN
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  assign beat_cnt_d = (en_q && dout_ready) ? beat_cnt_q + 1'b1 : beat_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) beat_cnt_q <= '0;
    else         beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule
